// File: rtl/jtpopeye_dwnld_pkg.sv
// Shared constants, FIFO entry type and CPU ROM decrypt helpers
// for the Popeye ROM download stage.
package jtpopeye_dwnld_pkg;

    localparam logic [21:0] CPU_END    = 22'h08000;
    localparam logic [21:0] GFX_END    = 22'h14000;
    localparam logic [21:0] PROM_END   = 22'h14240;
    localparam int          FIFO_DEPTH = 2;

    // first offset of each PROM bank, relative to GFX_END
    localparam logic [3:0][9:0] PROM_BASE = {
        10'h140, 10'h040, 10'h020, 10'h000
    };

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } prog_word_t;

    function automatic logic [7:0] data_swap(input logic [7:0] d);
        return {d[3], d[4], d[2], d[5], d[1], d[6], d[0], d[7]};
    endfunction

    // inverse of the CPU read-side address bit permutation
    function automatic logic [14:0] addr_perm(input logic [14:0] a);
        return {a[14:10], a[5], a[9], a[8], a[7],
                a[4], a[3], a[6], a[2:0]};
    endfunction

endpackage

// File: rtl/jtpopeye_dwnld_fifo.sv
// Two-entry skid FIFO between the ioctl decoder and the
// SDRAM programming port; head entry is the presented write.
module jtpopeye_dwnld_fifo
    import jtpopeye_dwnld_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  logic       i_pop,
    input  prog_word_t i_din,
    output prog_word_t o_head,
    output logic       o_empty,
    output logic       o_drop
);
    prog_word_t r_mem [FIFO_DEPTH];
    logic [1:0] r_cnt;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_slot;

    assign o_empty = (r_cnt == 2'd0);
    assign w_full  = (r_cnt == 2'd2);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && !w_push;
    // slot index after a same-cycle pop shifts the queue down
    assign w_slot  = r_cnt[0] ^ w_pop;
    assign o_head  = r_mem[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= 2'd0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            if (w_pop)
                r_mem[0] <= r_mem[1];
            if (w_push)
                r_mem[w_slot] <= i_din;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

endmodule

// File: rtl/jtpopeye_dwnld.sv
// Popeye ROM download stage: decrypts CPU bytes, routes ROM bytes
// to SDRAM through a skid FIFO and colour PROM bytes on-chip.
module jtpopeye_dwnld
    import jtpopeye_dwnld_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_downloading,
    input  logic [21:0] i_ioctl_addr,
    input  logic [7:0]  i_ioctl_data,
    input  logic        i_ioctl_wr,
    input  logic        i_prog_rdy,
    output logic [21:0] o_prog_addr,
    output logic [7:0]  o_prog_data,
    output logic [1:0]  o_prog_mask,
    output logic        o_prog_we,
    output logic [3:0]  o_prom_we,
    output logic [7:0]  o_prom_addr,
    output logic [7:0]  o_prom_data,
    output logic        o_dwnld_done,
    output logic        o_err_ovf
);
    logic [1:0]  r_state;
    logic        r_dl;
    logic        r_ovf;
    logic [3:0]  r_prom_we;
    logic [7:0]  r_prom_addr;
    logic [7:0]  r_prom_data;

    logic        w_rise;
    logic        w_fall;
    logic        w_load;
    logic        w_is_cpu;
    logic        w_is_gfx;
    logic        w_is_prom;
    logic        w_sdram;
    logic        w_prom_wr;
    logic [14:0] w_cpu_addr;
    logic [9:0]  w_off;
    logic [1:0]  w_bank;
    prog_word_t  w_word;
    prog_word_t  w_head;
    logic        w_empty;
    logic        w_drop;

    assign w_rise     = i_downloading & ~r_dl;
    assign w_fall     = ~i_downloading & r_dl;
    assign w_load     = (r_state == ST_LOAD);
    assign w_is_cpu   = (i_ioctl_addr < CPU_END);
    assign w_is_gfx   = !w_is_cpu && (i_ioctl_addr < GFX_END);
    assign w_is_prom  = (i_ioctl_addr >= GFX_END)
                     && (i_ioctl_addr < PROM_END);
    assign w_cpu_addr = addr_perm(i_ioctl_addr[14:0] ^ 15'h003F);
    assign w_off      = 10'(i_ioctl_addr - GFX_END);
    assign w_prom_wr  = w_load && i_ioctl_wr && w_is_prom;

    always_comb begin
        w_word  = '0;
        w_sdram = 1'b0;
        unique case (1'b1)
            w_is_cpu: begin
                w_sdram     = 1'b1;
                w_word.addr = {7'd0, w_cpu_addr} >> 1;
                w_word.data = data_swap(i_ioctl_data);
            end
            w_is_gfx: begin
                w_sdram     = 1'b1;
                w_word.addr = i_ioctl_addr >> 1;
                w_word.data = i_ioctl_data;
            end
            default: ;
        endcase
        // lane select follows the byte address as delivered
        w_word.mask = i_ioctl_addr[0] ? 2'b01 : 2'b10;
    end

    always_comb begin
        w_bank = 2'd0;
        unique case (1'b1)
            w_off < PROM_BASE[1]:
                w_bank = 2'd0;
            (w_off >= PROM_BASE[1]) && (w_off < PROM_BASE[2]):
                w_bank = 2'd1;
            (w_off >= PROM_BASE[2]) && (w_off < PROM_BASE[3]):
                w_bank = 2'd2;
            default:
                w_bank = 2'd3;
        endcase
    end

    jtpopeye_dwnld_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_load && i_ioctl_wr && w_sdram),
        .i_pop   (i_prog_rdy),
        .i_din   (w_word),
        .o_head  (w_head),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_dl        <= 1'b0;
            r_ovf       <= 1'b0;
            r_prom_we   <= 4'd0;
            r_prom_addr <= 8'd0;
            r_prom_data <= 8'd0;
        end else begin
            r_dl      <= i_downloading;
            r_ovf     <= r_ovf | w_drop;
            r_prom_we <= w_prom_wr ? (4'b0001 << w_bank) : 4'b0000;
            if (w_prom_wr) begin
                r_prom_addr <= 8'(w_off - PROM_BASE[w_bank]);
                r_prom_data <= i_ioctl_data;
            end
            unique case (r_state)
                ST_IDLE:
                    if (w_rise) r_state <= ST_LOAD;
                ST_LOAD:
                    if (w_fall) r_state <= ST_DRAIN;
                ST_DRAIN:
                    if (w_rise)       r_state <= ST_LOAD;
                    else if (w_empty) r_state <= ST_DONE;
                default:
                    r_state <= w_rise ? ST_LOAD : ST_IDLE;
            endcase
        end
    end

    assign o_prog_addr  = w_head.addr;
    assign o_prog_data  = w_head.data;
    assign o_prog_mask  = w_head.mask;
    assign o_prog_we    = !w_empty;
    assign o_prom_we    = r_prom_we;
    assign o_prom_addr  = r_prom_addr;
    assign o_prom_data  = r_prom_data;
    assign o_dwnld_done = (r_state == ST_DONE);
    assign o_err_ovf    = r_ovf;

endmodule

// File: tb/tb_jtpopeye_dwnld.sv
// Directed plus randomized bench for jtpopeye_dwnld against a
// queue-based reference of the download routing rules.
module tb_jtpopeye_dwnld;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dl;
    logic [21:0] addr;
    logic [7:0]  data;
    logic        wr;
    logic        rdy;
    logic [21:0] o_prog_addr;
    logic [7:0]  o_prog_data;
    logic [1:0]  o_prog_mask;
    logic        o_prog_we;
    logic [3:0]  o_prom_we;
    logic [7:0]  o_prom_addr;
    logic [7:0]  o_prom_data;
    logic        o_dwnld_done;
    logic        o_err_ovf;

    always #5 clk = ~clk;

    jtpopeye_dwnld dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_downloading (dl),
        .i_ioctl_addr  (addr),
        .i_ioctl_data  (data),
        .i_ioctl_wr    (wr),
        .i_prog_rdy    (rdy),
        .o_prog_addr   (o_prog_addr),
        .o_prog_data   (o_prog_data),
        .o_prog_mask   (o_prog_mask),
        .o_prog_we     (o_prog_we),
        .o_prom_we     (o_prom_we),
        .o_prom_addr   (o_prom_addr),
        .o_prom_data   (o_prom_data),
        .o_dwnld_done  (o_dwnld_done),
        .o_err_ovf     (o_err_ovf)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // MAME-style source bit lists, MSB first
    localparam int SWAP_SRC [8]  = '{3, 4, 2, 5, 1, 6, 0, 7};
    localparam int PERM_SRC [15] = '{14, 13, 12, 11, 10, 8, 7, 6,
                                     3, 9, 5, 4, 2, 1, 0};
    localparam int BANK_BASE [4] = '{0, 32, 64, 320};

    typedef struct packed {
        logic [21:0] a;
        logic [7:0]  d;
        logic [1:0]  m;
    } wr_t;

    wr_t         q [$];
    logic [14:0] inv_tab [32768];
    bit          m_load, m_drain, m_prevdl, m_ovf, m_done;
    logic [3:0]  m_pwe;
    logic [7:0]  m_paddr, m_pdata;

    function automatic logic [7:0] ref_swap(input logic [7:0] d);
        logic [7:0] o;
        for (int k = 0; k < 8; k++) o[7-k] = d[SWAP_SRC[k]];
        return o;
    endfunction

    function automatic logic [14:0] fwd_perm(input logic [14:0] i);
        logic [14:0] j;
        for (int k = 0; k < 15; k++) j[14-k] = i[PERM_SRC[k]];
        return j;
    endfunction

    function automatic wr_t ref_word(input logic [21:0] a,
                                     input logic [7:0] d);
        wr_t w;
        if (a < 22'h08000) begin
            w.a = {7'd0, inv_tab[a[14:0] ^ 15'h003F]} >> 1;
            w.d = ref_swap(d);
        end else begin
            w.a = a >> 1;
            w.d = d;
        end
        w.m = a[0] ? 2'b01 : 2'b10;
        return w;
    endfunction

    function automatic int ref_bank(input int off);
        if (off < 32)  return 0;
        if (off < 64)  return 1;
        if (off < 320) return 2;
        return 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  pre, ia, off, b;
        bit  rise, fall, acc;
        if (!rst_n) begin
            q.delete();
            m_load = 0; m_drain = 0; m_prevdl = 0;
            m_ovf = 0; m_done = 0; m_pwe = 4'd0;
            return;
        end
        pre  = q.size();
        rise = dl && !m_prevdl;
        fall = !dl && m_prevdl;
        acc  = m_load;
        m_done = 0;
        if (rise) begin
            m_load = 1; m_drain = 0;
        end else if (fall && m_load) begin
            m_load = 0; m_drain = 1;
        end else if (m_drain && pre == 0) begin
            m_drain = 0; m_done = 1;
        end
        m_prevdl = dl;
        if (rdy && pre > 0) void'(q.pop_front());
        m_pwe = 4'd0;
        if (acc && wr) begin
            ia = int'(addr);
            if (ia < 'h14000) begin
                if (q.size() < 2) q.push_back(ref_word(addr, data));
                else m_ovf = 1;
            end else if (ia < 'h14240) begin
                off     = ia - 'h14000;
                b       = ref_bank(off);
                m_pwe   = 4'(1 << b);
                m_paddr = 8'(off - BANK_BASE[b]);
                m_pdata = data;
            end
        end
    endtask

    task automatic check_out();
        chk("prog_we", o_prog_we, q.size() > 0);
        if (q.size() > 0) begin
            chk("prog_addr", o_prog_addr, q[0].a);
            chk("prog_data", o_prog_data, q[0].d);
            chk("prog_mask", o_prog_mask, q[0].m);
        end
        chk("prom_we", o_prom_we, m_pwe);
        if (m_pwe != 4'd0) begin
            chk("prom_addr", o_prom_addr, m_paddr);
            chk("prom_data", o_prom_data, m_pdata);
        end
        chk("dwnld_done", o_dwnld_done, m_done);
        chk("err_ovf", o_err_ovf, m_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_out();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, o_prog_addr, 0);
        chk({tag, "_data"}, o_prog_data, 0);
        chk({tag, "_mask"}, o_prog_mask, 0);
        chk({tag, "_we"}, o_prog_we, 0);
        chk({tag, "_prom_we"}, o_prom_we, 0);
        chk({tag, "_prom_addr"}, o_prom_addr, 0);
        chk({tag, "_prom_data"}, o_prom_data, 0);
        chk({tag, "_done"}, o_dwnld_done, 0);
        chk({tag, "_ovf"}, o_err_ovf, 0);
    endtask

    task automatic put(input logic [21:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; data = d;
        tick();
        wr = 1'b0;
    endtask

    initial begin
        int region;
        rst_n = 1'b0; dl = 1'b0; wr = 1'b0; rdy = 1'b0;
        addr = '0; data = '0;
        for (int i = 0; i < 32768; i++)
            inv_tab[fwd_perm(15'(i))] = 15'(i);

        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1; dl = 1'b1;
        tick(); tick();

        rdy = 1'b1;
        put(22'h00000, 8'h01);
        chk("cpu01_we", o_prog_we, 1);
        chk("cpu01_data", o_prog_data, 8'h02);
        chk("cpu01_addr", o_prog_addr, 22'h00011B);
        chk("cpu01_mask", o_prog_mask, 2'b10);
        tick();
        chk("cpu01_drop", o_prog_we, 0);
        put(22'h00000, 8'h80);
        chk("cpu80_data", o_prog_data, 8'h01);
        chk("cpu80_addr", o_prog_addr, 22'h00011B);
        chk("cpu80_mask", o_prog_mask, 2'b10);
        tick();

        put(22'h08003, 8'hA5);
        chk("gfx_we", o_prog_we, 1);
        chk("gfx_addr", o_prog_addr, 22'h04001);
        chk("gfx_data", o_prog_data, 8'hA5);
        chk("gfx_mask", o_prog_mask, 2'b01);
        tick();
        chk("gfx_we_1cyc", o_prog_we, 0);

        put(22'h14045, 8'h3C);
        chk("prom_we", o_prom_we, 4'b0100);
        chk("prom_addr", o_prom_addr, 8'h05);
        chk("prom_data", o_prom_data, 8'h3C);
        chk("prom_no_prog", o_prog_we, 0);
        tick();
        chk("prom_we_1cyc", o_prom_we, 4'b0000);

        rdy = 1'b0;
        put(22'h08000, 8'h11);
        put(22'h08001, 8'h22);
        put(22'h08002, 8'h33);
        chk("ovf_flag", o_err_ovf, 1);
        chk("ovf_head_data", o_prog_data, 8'h11);
        chk("ovf_head_addr", o_prog_addr, 22'h04000);
        chk("ovf_head_mask", o_prog_mask, 2'b10);
        rdy = 1'b1;
        tick();
        chk("ovf_2nd_we", o_prog_we, 1);
        chk("ovf_2nd_data", o_prog_data, 8'h22);
        chk("ovf_2nd_mask", o_prog_mask, 2'b01);
        tick();
        chk("ovf_empty", o_prog_we, 0);

        rdy = 1'b0;
        put(22'h08010, 8'h5A);
        chk("mid_we", o_prog_we, 1);
        rst_n = 1'b0;
        tick();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        tick(); tick();

        repeat (400) begin
            wr     = 1'($urandom_range(0, 1));
            region = int'($urandom_range(0, 3));
            case (region)
                0: addr = 22'($urandom_range(0, 'h7FFF));
                1: addr = 22'($urandom_range('h8000, 'h13FFF));
                2: addr = 22'($urandom_range('h14000, 'h1423F));
                default: addr = 22'($urandom_range('h14240, 'h3FFFFF));
            endcase
            data = 8'($urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            tick();
        end

        wr = 1'b0; rdy = 1'b1;
        tick(); tick(); tick();
        rdy = 1'b0;
        put(22'h08020, 8'h77);
        dl = 1'b0;
        tick();
        chk("drain_pend_done", o_dwnld_done, 0);
        chk("drain_pend_we", o_prog_we, 1);
        tick();
        chk("drain_stall_done", o_dwnld_done, 0);
        rdy = 1'b1;
        tick();
        chk("drain_pop_we", o_prog_we, 0);
        chk("drain_pop_done", o_dwnld_done, 0);
        tick();
        chk("drain_done_pulse", o_dwnld_done, 1);
        tick();
        chk("drain_done_once", o_dwnld_done, 0);

        dl = 1'b1;
        tick(); tick();
        rdy = 1'b0;
        put(22'h08030, 8'h99);
        dl = 1'b0;
        tick();
        dl = 1'b1;
        tick();
        rdy = 1'b1;
        repeat (4) begin
            tick();
            chk("reload_no_done", o_dwnld_done, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_miss);
        $finish;
    end

endmodule
